// File: rtl/fft_stream_mux_if.sv
// Handshake/bus bundle for fft_stream_mux.
//   in_data   : NUM_INPUTS packed samples, channel k at [k*DW +: DW]
//   in_valid  : per-channel sample valid
//   in_ready  : per-channel accept, at most one bit high
//   out_data  : registered selected sample
//   out_ch    : source channel of out_data
//   out_valid : out_data holds a sample
//   out_ready : downstream accepts
//   out_last  : sweep-mode sample came from the last channel
// Modports: slave = mux side, master = producer/consumer side.
interface fft_stream_mux_if #(
  parameter int NUM_INPUTS = 4,
  parameter int DW         = 44,
  parameter int SEL_W      = 2
);
  logic [NUM_INPUTS*DW-1:0] in_data;
  logic [NUM_INPUTS-1:0]    in_valid;
  logic [NUM_INPUTS-1:0]    in_ready;
  logic [DW-1:0]            out_data;
  logic [SEL_W-1:0]         out_ch;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid, out_last
  );
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid, out_last
  );
endinterface

// File: rtl/fft_stream_mux.sv
// Registered N:1 selector for complex FFT samples ({re,im}, 2*number_bits wide)
// feeding the butterfly input stage. Grant modes: 00 static, 01 round-robin,
// 10 fixed priority, 11 sequential sweep.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   mode       : grant mode
//   sel        : channel index used in static mode
//   bus        : sample handshake bundle (slave side)
//   sel_err    : sticky, static mode used with sel >= NUM_INPUTS
module fft_stream_mux #(
  parameter int number_bits = 22,
  parameter int NUM_INPUTS  = 4,
  parameter int SEL_W       = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel,
  fft_stream_mux_if.slave  bus,
  output logic             sel_err
);
  localparam int DW = 2*number_bits;
  typedef logic [SEL_W-1:0] idx_t;

  logic [DW-1:0] out_data_q, out_data_d;
  idx_t          out_ch_q, out_ch_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          sel_err_q, sel_err_d;
  idx_t          rr_ptr_q, rr_ptr_d;
  idx_t          seq_idx_q, seq_idx_d;

  logic                  load_en, grant_found, xfer, sel_bad;
  idx_t                  g;
  logic [NUM_INPUTS-1:0] in_ready;

  assign load_en = ~out_valid_q | bus.out_ready;
  assign sel_bad = int'(sel) >= NUM_INPUTS;

  // Grant selection. Loops run from the highest candidate down so the last
  // hit (lowest index / nearest to rr_ptr) wins without a break.
  always_comb begin
    g           = '0;
    grant_found = 1'b0;
    case (mode)
      2'b00: begin
        if (!sel_bad) begin
          g           = sel;
          grant_found = 1'b1;
        end
      end
      2'b01: begin
        for (int i = NUM_INPUTS-1; i >= 0; i--) begin
          int k;
          k = int'(rr_ptr_q) + i;
          if (k >= NUM_INPUTS) k = k - NUM_INPUTS;
          if (bus.in_valid[k]) begin
            g           = idx_t'(k);
            grant_found = 1'b1;
          end
        end
      end
      2'b10: begin
        for (int i = NUM_INPUTS-1; i >= 0; i--) begin
          if (bus.in_valid[i]) begin
            g           = idx_t'(i);
            grant_found = 1'b1;
          end
        end
      end
      default: begin
        // sweep waits on seq_idx only, so the grant exists regardless of valid
        g           = seq_idx_q;
        grant_found = 1'b1;
      end
    endcase
  end

  // rst_n gates in_ready so nothing is accepted while reset is held
  always_comb begin
    in_ready = '0;
    if (rst_n && load_en && grant_found) in_ready[g] = 1'b1;
  end

  assign xfer = |(in_ready & bus.in_valid);

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    rr_ptr_d    = rr_ptr_q;
    seq_idx_d   = seq_idx_q;
    sel_err_d   = sel_err_q | ((mode == 2'b00) & sel_bad);
    if (load_en) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = bus.in_data[g*DW +: DW];
        out_ch_d   = g;
        out_last_d = (mode == 2'b11) && (int'(g) == NUM_INPUTS-1);
        if (mode == 2'b01)
          rr_ptr_d = (int'(g) == NUM_INPUTS-1) ? '0 : g + 1'b1;
        if (mode == 2'b11)
          seq_idx_d = (int'(seq_idx_q) == NUM_INPUTS-1) ? '0 : seq_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      sel_err_q   <= 1'b0;
      rr_ptr_q    <= '0;
      seq_idx_q   <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      sel_err_q   <= sel_err_d;
      rr_ptr_q    <= rr_ptr_d;
      seq_idx_q   <= seq_idx_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign sel_err       = sel_err_q;
endmodule

// File: tb/tb_fft_stream_mux.sv
module tb_fft_stream_mux;
  localparam int NB = 22;
  localparam int DW = 2*NB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] mode4, mode3, sel4, sel3;
  logic       err4, err3;

  fft_stream_mux_if #(.NUM_INPUTS(4), .DW(DW), .SEL_W(2)) b4 ();
  fft_stream_mux_if #(.NUM_INPUTS(3), .DW(DW), .SEL_W(2)) b3 ();

  fft_stream_mux #(.number_bits(NB), .NUM_INPUTS(4), .SEL_W(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode4), .sel(sel4), .bus(b4.slave), .sel_err(err4));
  fft_stream_mux #(.number_bits(NB), .NUM_INPUTS(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3), .bus(b3.slave), .sel_err(err3));

  typedef struct packed {
    logic [1:0]    ch;
    logic          last;
    logic [DW-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  function automatic logic [DW-1:0] pat(input int tag, input int k);
    return {22'(tag), 22'(32'h2A000 + k)};
  endfunction

  task automatic drive_all(input int tag);
    for (int k = 0; k < 4; k++) b4.in_data[k*DW +: DW] = pat(tag, k);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    mode4 = 2'b00; sel4 = 2'd0; mode3 = 2'b00; sel3 = 2'd0;
    b4.in_valid = 4'hF; b4.out_ready = 1'b1; drive_all(1);
    b3.in_valid = 3'b000; b3.out_ready = 1'b1; b3.in_data = '0;
    rst_n = 1'b0;
    #12;
    total_cnt++;
    if ({b4.out_valid, b4.out_data, b4.out_ch, b4.out_last, err4, b4.in_ready} !== '0)
      $display("FAIL reset_state: got v=%b d=%h ch=%0d l=%b err=%b rdy=%b want all 0",
               b4.out_valid, b4.out_data, b4.out_ch, b4.out_last, err4, b4.in_ready);
    else pass_cnt++;
    b4.in_valid = 4'h0;
    @(negedge clk) rst_n = 1'b1;
    step();
    total_cnt++;
    if (b4.out_valid !== 1'b0) $display("FAIL reset_idle: out_valid=%b want 0", b4.out_valid);
    else pass_cnt++;
  endtask

  task automatic test_static();
    mode4 = 2'b00; sel4 = 2'd2; b4.in_valid = 4'hF; drive_all(2);
    b4.in_data[2*DW +: DW] = 44'h0AB_CDE;
    #1;
    total_cnt++;
    if (b4.in_ready !== 4'b0100) $display("FAIL static_ready: got %b want 0100", b4.in_ready);
    else pass_cnt++;
    exp_q.push_back('{ch: 2'd2, last: 1'b0, d: 44'h0AB_CDE});
    step();
    e = exp_q.pop_front();
    total_cnt++;
    if ({b4.out_valid, b4.out_ch, b4.out_last, b4.out_data} !== {1'b1, e})
      $display("FAIL static_out: got v=%b ch=%0d l=%b d=%h want ch=%0d d=%h",
               b4.out_valid, b4.out_ch, b4.out_last, b4.out_data, e.ch, e.d);
    else pass_cnt++;
    b4.in_valid = 4'h0;
    // out-of-range select on the 3-channel instance
    sel3 = 2'd3; b3.in_valid = 3'b111;
    #1;
    total_cnt++;
    if (b3.in_ready !== 3'b000) $display("FAIL static_badsel_ready: got %b want 000", b3.in_ready);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({b3.out_valid, err3, err4} !== 3'b010)
      $display("FAIL static_badsel: got v=%b err3=%b err4=%b want 0 1 0", b3.out_valid, err3, err4);
    else pass_cnt++;
    b3.in_valid = 3'b000; sel3 = 2'd0;
  endtask

  task automatic test_round_robin();
    int seq2 [5] = '{0, 2, 3, 0, 2};
    mode4 = 2'b01;
    for (int c = 0; c < 13; c++) begin
      int ch;
      b4.in_valid = (c < 8) ? 4'hF : 4'b1101;
      ch = (c < 8) ? c % 4 : seq2[c-8];
      drive_all(100 + c);
      #1;
      total_cnt++;
      if (b4.in_ready !== (4'b0001 << ch))
        $display("FAIL rr_ready c=%0d: got %b want ch %0d", c, b4.in_ready, ch);
      else pass_cnt++;
      exp_q.push_back('{ch: 2'(ch), last: 1'b0, d: pat(100 + c, ch)});
      step();
      e = exp_q.pop_front();
      total_cnt++;
      if ({b4.out_valid, b4.out_ch, b4.out_last, b4.out_data} !== {1'b1, e})
        $display("FAIL rr_out c=%0d: got v=%b ch=%0d l=%b d=%h want ch=%0d d=%h",
                 c, b4.out_valid, b4.out_ch, b4.out_last, b4.out_data, e.ch, e.d);
      else pass_cnt++;
    end
  endtask

  task automatic test_priority();
    mode4 = 2'b10;
    for (int c = 0; c < 5; c++) begin
      int ch;
      b4.in_valid = (c < 3) ? 4'b1010 : 4'b1000;
      ch = (c < 3) ? 1 : 3;
      drive_all(200 + c);
      exp_q.push_back('{ch: 2'(ch), last: 1'b0, d: pat(200 + c, ch)});
      step();
      e = exp_q.pop_front();
      total_cnt++;
      if ({b4.out_valid, b4.out_ch, b4.out_last, b4.out_data} !== {1'b1, e})
        $display("FAIL prio_out c=%0d: got v=%b ch=%0d d=%h want ch=%0d d=%h",
                 c, b4.out_valid, b4.out_ch, b4.out_data, e.ch, e.d);
      else pass_cnt++;
    end
  endtask

  task automatic test_sweep();
    int nxt = 0;
    mode4 = 2'b11;
    for (int c = 0; c < 24; c++) begin
      logic hit;
      b4.in_valid = 4'($urandom_range(0, 15));
      drive_all(500 + c);
      hit = b4.in_valid[nxt];
      if (hit) begin
        exp_q.push_back('{ch: 2'(nxt), last: (nxt == 3), d: pat(500 + c, nxt)});
        nxt = (nxt + 1) % 4;
      end
      step();
      total_cnt++;
      if (hit) begin
        e = exp_q.pop_front();
        if ({b4.out_valid, b4.out_ch, b4.out_last, b4.out_data} !== {1'b1, e})
          $display("FAIL sweep_out c=%0d: got v=%b ch=%0d l=%b d=%h want ch=%0d l=%b d=%h",
                   c, b4.out_valid, b4.out_ch, b4.out_last, b4.out_data, e.ch, e.last, e.d);
        else pass_cnt++;
      end else begin
        if (b4.out_valid !== 1'b0) $display("FAIL sweep_idle c=%0d: out_valid=%b want 0", c, b4.out_valid);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t held;
    mode4 = 2'b10; b4.in_valid = 4'b0001; b4.out_ready = 1'b1; drive_all(300);
    exp_q.push_back('{ch: 2'd0, last: 1'b0, d: pat(300, 0)});
    step();
    held = exp_q.pop_front();
    b4.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive_all(310 + c);
      #1;
      total_cnt++;
      if (b4.in_ready !== 4'b0000) $display("FAIL bp_ready c=%0d: got %b want 0000", c, b4.in_ready);
      else pass_cnt++;
      step();
      total_cnt++;
      if ({b4.out_valid, b4.out_ch, b4.out_last, b4.out_data} !== {1'b1, held})
        $display("FAIL bp_hold c=%0d: got v=%b ch=%0d d=%h want d=%h",
                 c, b4.out_valid, b4.out_ch, b4.out_data, held.d);
      else pass_cnt++;
    end
    b4.out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive_all(400 + c);
      #1;
      total_cnt++;
      if (b4.in_ready !== 4'b0001) $display("FAIL bp_resume_ready c=%0d: got %b want 0001", c, b4.in_ready);
      else pass_cnt++;
      exp_q.push_back('{ch: 2'd0, last: 1'b0, d: pat(400 + c, 0)});
      step();
      e = exp_q.pop_front();
      total_cnt++;
      if ({b4.out_valid, b4.out_ch, b4.out_last, b4.out_data} !== {1'b1, e})
        $display("FAIL bp_resume c=%0d: got v=%b d=%h want d=%h", c, b4.out_valid, b4.out_data, e.d);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    mode4 = 2'b10; b4.in_valid = 4'b0001; drive_all(600);
    step();
    total_cnt++;
    if ({b4.out_valid, err3} !== 2'b11)
      $display("FAIL mid_pre: got v=%b err3=%b want 1 1", b4.out_valid, err3);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({b4.out_valid, b4.in_ready, err3} !== 6'b0)
      $display("FAIL mid_reset: got v=%b rdy=%b err3=%b want 0", b4.out_valid, b4.in_ready, err3);
    else pass_cnt++;
    @(negedge clk) rst_n = 1'b1;
    drive_all(601);
    #1;
    total_cnt++;
    if ({b4.out_valid, b4.in_ready} !== 5'b00001)
      $display("FAIL mid_release: got v=%b rdy=%b want 0 0001", b4.out_valid, b4.in_ready);
    else pass_cnt++;
    exp_q.push_back('{ch: 2'd0, last: 1'b0, d: pat(601, 0)});
    step();
    e = exp_q.pop_front();
    total_cnt++;
    if ({b4.out_valid, b4.out_ch, b4.out_last, b4.out_data} !== {1'b1, e})
      $display("FAIL mid_first: got v=%b d=%h want d=%h", b4.out_valid, b4.out_data, e.d);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_static();
    test_round_robin();
    test_priority();
    test_sweep();
    test_back_to_back();
    test_reset_mid();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
